filtro_biquad_seq: RTL
======================

Name: filtro_biquad_seq

Overview:
- Parametrised second-order IIR section, direct form II: f(k) = u(k) − a1·f(k−1) − a2·f(k−2); y(k) = b0·f(k) + b1·f(k−1) + b2·f(k−2).
- Successor to the externally sequenced filter datapaths: an internal FSM drives one shared multiply-accumulate, so upper-level control reduces to a valid/ready sample handshake.
- Coefficients are port inputs, so one block serves low-pass and high-pass roles.

Parameters:
- W, 16, signed two's-complement width of samples, coefficients, state and output.
- FRAC, 8, fractional bits of the coefficients (Q(W−FRAC).FRAC).
- ACCW, 2*W+3, accumulator width; must be ≥ 2*W+3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- clr  input  1  synchronous state flush, active-high.
- u_valid  input  1  input sample valid.
- u  input  W  input sample, signed.
- ready  output  1  block idle; sample accepted on edge with u_valid & ready.
- b0, b1, b2, a1, a2  input  W each  signed coefficients, QFRAC.
- y  output  W  filtered sample, signed.
- y_valid  output  1  one-cycle strobe, y updated.

Behaviour:
- Reset (reset==0 at edge): state IDLE; f1, f2, y, acc = 0; y_valid = 0; ready = 1 in the following cycle. Reset overrides clr and any in-flight computation.
- clr==1 at edge (reset high): same effect as reset; the current computation is aborted with no y_valid.
- ready = (state==IDLE), combinational from state.
- Acceptance edge k (u_valid & ready):
  - u and all five coefficients are latched; acc <= sext(u) <<< FRAC.
  - Coefficient changes after edge k are ignored for this sample.
- FSM sequence, one state per edge:
  - F1: acc -= a1·f1.
  - F2: acc -= a2·f2.
  - FSAT: f <= conv(acc); acc <= 0.
  - Y0: acc += b0·f.
  - Y1: acc += b1·f1.
  - Y2: acc += b2·f2.
  - DONE: y <= conv(acc); f2 <= f1; f1 <= f; y_valid <= 1; next state IDLE.
- Timing:
  - The DONE action occurs at edge k+7. y_valid is high only in the cycle after edge k+7; y holds its value until the next DONE, clr or reset.
  - Earliest next acceptance is edge k+8, i.e. throughput 1 sample per 8 clocks.
- u_valid while ready==0: ignored. No queuing; the sample is lost.
- Products are full W×W signed, sign-extended to ACCW. No overflow inside acc for ACCW ≥ 2W+3.
- conv(x) = x >>> FRAC (arithmetic shift, floor rounding), then reduced to W bits per the optional feature.
- f stored in f1/f2 is the converted W-bit value, so the same rules apply to the state.

Optional Feature:
- Macro: BIQUAD_SAT_EN.
- When defined: conv clamps to [−2^(W−1), 2^(W−1)−1] (saturating), for both f and y.
- When undefined: conv keeps the low W bits (two's-complement wrap). No clamp logic is synthesised.

Test Plan (W=16, FRAC=8):
- Identity: b0=256, others 0, u=100 accepted at edge k → y=100, y_valid high only after edge k+7; ready low between edges k and k+7.
- Recursion: b0=256, a1=−128, a2=b1=b2=0; inputs 256, 0, 0 at 8-cycle spacing → y = 256, 128, 64; f1 = 64 after the third sample.
- Floor rounding: b0=128, u=−1 → y=−1. Then u=1 → y=0.
- Overflow: b0=512, u=20000 → y=32767 with BIQUAD_SAT_EN; y=−25536 without it.
- Handshake: hold u_valid=1 with u=5, then 7 changing at edge k+3 during busy → only u=5 processed; next acceptance at edge k+8 takes the current u.
- Abort: clr=1 at edge k+4, then reset=0 mid-run of another sample → no y_valid; y, f1, f2 = 0; ready=1 the next cycle; a following identity sample u=9 yields y=9.

Source files
------------

// File: rtl/filtro_biquad_seq.sv
// Direct-form-II biquad section built around one shared multiply-accumulate.
// Define BIQUAD_SAT_EN to saturate f and y on conversion instead of wrapping.
module filtro_biquad_seq #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 2*W+3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                u_valid,
    input  logic signed [W-1:0] u,
    output logic                ready,
    input  logic signed [W-1:0] b0,
    input  logic signed [W-1:0] b1,
    input  logic signed [W-1:0] b2,
    input  logic signed [W-1:0] a1,
    input  logic signed [W-1:0] a2,
    output logic signed [W-1:0] y,
    output logic                y_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_FSAT,
        S_Y0,
        S_Y1,
        S_Y2,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [W-1:0]    b0_q, b0_d;
    logic signed [W-1:0]    b1_q, b1_d;
    logic signed [W-1:0]    b2_q, b2_d;
    logic signed [W-1:0]    a1_q, a1_d;
    logic signed [W-1:0]    a2_q, a2_d;
    logic signed [W-1:0]    f_q, f_d;
    logic signed [W-1:0]    f1_q, f1_d;
    logic signed [W-1:0]    f2_q, f2_d;
    logic signed [W-1:0]    y_q, y_d;
    logic                   y_valid_q, y_valid_d;

    logic signed [W-1:0]      mul_c;
    logic signed [W-1:0]      mul_d;
    logic signed [2*W-1:0]    prod;
    logic signed [ACCW-1:0]   prod_ext;
    logic signed [ACCW-1:0]   u_ext;

    function automatic logic signed [W-1:0] conv(
        input logic signed [ACCW-1:0] x
    );
`ifdef BIQUAD_SAT_EN
        logic signed [ACCW-1:0] sh;
        sh = x >>> FRAC;
        // In range when every bit above the W-bit sign agrees with it
        if ((&sh[ACCW-1:W-1]) || (~|sh[ACCW-1:W-1])) begin
            conv = sh[W-1:0];
        end else if (sh[ACCW-1]) begin
            conv = {1'b1, {(W-1){1'b0}}};
        end else begin
            conv = {1'b0, {(W-1){1'b1}}};
        end
`else
        conv = W'(x >>> FRAC);
`endif
    endfunction

    // Operand steering for the shared multiplier
    always_comb begin
        mul_c = '0;
        mul_d = '0;
        unique case (state_q)
            S_F1: begin
                mul_c = a1_q;
                mul_d = f1_q;
            end
            S_F2: begin
                mul_c = a2_q;
                mul_d = f2_q;
            end
            S_Y0: begin
                mul_c = b0_q;
                mul_d = f_q;
            end
            S_Y1: begin
                mul_c = b1_q;
                mul_d = f1_q;
            end
            S_Y2: begin
                mul_c = b2_q;
                mul_d = f2_q;
            end
            default: begin
                mul_c = '0;
                mul_d = '0;
            end
        endcase
    end

    assign prod     = mul_c * mul_d;
    assign prod_ext = {{(ACCW-2*W){prod[2*W-1]}}, prod};
    assign u_ext    = {{(ACCW-W){u[W-1]}}, u};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        f_d       = f_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (u_valid) begin
                    b0_d    = b0;
                    b1_d    = b1;
                    b2_d    = b2;
                    a1_d    = a1;
                    a2_d    = a2;
                    acc_d   = u_ext <<< FRAC;
                    state_d = S_F1;
                end
            end
            S_F1: begin
                acc_d   = acc_q - prod_ext;
                state_d = S_F2;
            end
            S_F2: begin
                acc_d   = acc_q - prod_ext;
                state_d = S_FSAT;
            end
            S_FSAT: begin
                f_d     = conv(acc_q);
                acc_d   = '0;
                state_d = S_Y0;
            end
            S_Y0: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_Y1;
            end
            S_Y1: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_Y2;
            end
            S_Y2: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_DONE;
            end
            S_DONE: begin
                y_d       = conv(acc_q);
                f2_d      = f1_q;
                f1_d      = f_q;
                y_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // clr behaves exactly like reset, aborting any sample in flight
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            f_q       <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            f_q       <= f_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
